kogge_stone_arbiter: RTL and testbench
======================================

// Module: kogge_stone_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one pipelined kogge_stone_Nbit adder among NREQ requesters.
//  Accepts at most one add request per cycle, drives the adder operand registers, and tracks request
//  IDs through the adder latency so each result returns tagged to its originator.
//  Sits between client datapaths and a single adder instance.
// PARAMETERS
//  BW    32  operand/sum width in bits
//  NREQ  4   number of requesters (2..8)
//  LAT   2   adder latency in clk edges from registered operands to valid sum (0..8)
// PORTS
//  clk        in   1         rising-edge clock
//  resetn     in   1         synchronous reset, active-low
//  req_valid  in   NREQ      per-requester request valid
//  req_ready  out  NREQ      one-hot grant; transfer on valid&ready at the clk edge
//  req_a      in   NREQ*BW   operand A, requester i at [i*BW +: BW]
//  req_b      in   NREQ*BW   operand B, same packing
//  req_cin    in   NREQ      carry-in per requester
//  add_a      out  BW        registered operand A to adder
//  add_b      out  BW        registered operand B to adder
//  add_cin    out  1         registered carry-in to adder
//  add_sum    in   BW        adder sum
//  add_cout   in   1         adder carry-out
//  rsp_valid  out  NREQ      one-hot result valid (registered)
//  rsp_sum    out  BW        = add_sum, meaningful when |rsp_valid
//  rsp_cout   out  1         = add_cout, meaningful when |rsp_valid
//  idle       out  1         no tag in flight and req_valid==0
//  grant_cnt  out  16        issued-request count (only with KS_ARB_STATS_EN)
// BEHAVIOUR
//  - Reset (resetn=0 at edge): rr pointer=0, add_a/add_b/add_cin=0, tag pipe cleared, rsp_valid=0,
//    grant_cnt=0. req_ready is 0 while resetn=0. In-flight results are dropped: no rsp_valid after reset.
//  - Grant: combinational from req_valid and rr pointer; search upward from pointer, wrap at NREQ-1->0;
//    first valid index wins. At most one bit of req_ready set. No valid -> req_ready=0.
//  - Pointer: on transfer by requester g, pointer <= (g+1) mod NREQ; unchanged if no transfer.
//  - Requester must hold req_valid and operands stable until its transfer; dropping valid before
//    grant is allowed (request withdrawn, nothing issued).
//  - Issue: on transfer edge t0, add_a/add_b/add_cin <= requester g operands; tag {1,g} enters tag pipe.
//    No transfer -> operand registers hold, bubble tag {0,x} enters.
//  - Tag pipe depth LAT+1; rsp_valid <= onehot(g) in the cycle after edge t0+LAT (response LAT cycles
//    after transfer cycle; LAT=0 -> cycle immediately after transfer). rsp_sum/rsp_cout pass add_sum/add_cout.
//  - Throughput 1 add/cycle; results return in issue order; no response backpressure (clients must sink).
//  - Arithmetic: {rsp_cout,rsp_sum} = a + b + cin modulo 2^(BW+1); overflow carries only into rsp_cout.
//  - Simultaneous new request and response for same requester both proceed in that cycle.
//  - idle is combinational: ~|tag-valid bits & ~|req_valid.
// CONFIGURATION
//  KS_ARB_STATS_EN defined: grant_cnt port present; increments by 1 per transfer, saturates at 16'hFFFF,
//   cleared by reset. Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  - Single: req0 a=100000 b=100000 cin=1, LAT=2 -> ready0 same cycle; rsp_valid=4'b0001,
//    sum=200001, cout=0 two cycles after transfer.
//  - Contention: req_valid=4'b1111 held from reset -> grants 0,1,2,3,0 on successive cycles; rsp_valid
//    one-hot in same order, no gaps.
//  - Fairness: req0 valid constantly, req2 pulses -> req2 granted within NREQ cycles of asserting; never starved.
//  - Wrap: a=32'hFFFFFFFF b=0 cin=1 -> sum=0 cout=1; a=b=32'hFFFFFFFF cin=1 -> sum=32'hFFFFFFFF cout=1.
//  - Reset mid-flight: 3 tags in flight, resetn=0 one cycle -> rsp_valid stays 0, pointer=0, idle=1.
//  - Stats (KS_ARB_STATS_EN): 70000 transfers -> grant_cnt=16'hFFFF and holds; reset -> 0.

Source files
------------

// File: rtl/kogge_stone_arbiter_if.sv
// Client-side bundle for kogge_stone_arbiter: per-requester add requests and tagged results.
interface kogge_stone_arbiter_if #(
  parameter int BW   = 32,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*BW-1:0] req_a;
  logic [NREQ*BW-1:0] req_b;
  logic [NREQ-1:0]    req_cin;
  logic [NREQ-1:0]    rsp_valid;
  logic [BW-1:0]      rsp_sum;
  logic               rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin,
    output req_ready, rsp_valid, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/kogge_stone_arbiter.sv
// Round-robin sequencer sharing one pipelined adder among NREQ clients, returning tagged results.
// Optional KS_ARB_STATS_EN adds a saturating 16-bit transfer counter on grant_cnt.
module kogge_stone_arbiter #(
  parameter int BW   = 32,
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  kogge_stone_arbiter_if.slave  cl,
  output logic [BW-1:0]         add_a,
  output logic [BW-1:0]         add_b,
  output logic                  add_cin,
  input  logic [BW-1:0]         add_sum,
  input  logic                  add_cout,
  output logic                  idle
`ifdef KS_ARB_STATS_EN
  ,
  output logic [15:0]           grant_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]           ptr;
  logic [PW-1:0]           gidx;
  logic [PW-1:0]           nptr;
  logic                    gvld;
  logic                    xfer;
  logic [NREQ-1:0]         gnt;
  logic [LAT:0][NREQ-1:0]  tag_pipe;

  // Search upward from the pointer with wrap; first valid requester wins.
  always_comb begin
    int idx;
    idx  = 0;
    gidx = '0;
    gvld = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr) + off) % NREQ;
      if (!gvld && cl.req_valid[idx]) begin
        gvld = 1'b1;
        gidx = PW'(idx);
      end
    end
  end

  assign xfer = gvld & resetn;

  always_comb begin
    gnt = '0;
    if (xfer) gnt[gidx] = 1'b1;
  end

  always_comb begin
    nptr = gidx + PW'(1);
    if (int'(gidx) == NREQ - 1) nptr = '0;
  end

  assign cl.req_ready = gnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr      <= '0;
      add_a    <= '0;
      add_b    <= '0;
      add_cin  <= 1'b0;
      tag_pipe <= '0;
    end else begin
      if (xfer) begin
        ptr     <= nptr;
        add_a   <= cl.req_a[gidx*BW +: BW];
        add_b   <= cl.req_b[gidx*BW +: BW];
        add_cin <= cl.req_cin[gidx];
      end
      // Tags are one-hot requester ids; an all-zero entry is a bubble.
      tag_pipe[0] <= gnt;
      for (int k = 1; k <= LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  assign cl.rsp_valid = tag_pipe[LAT];
  assign cl.rsp_sum   = add_sum;
  assign cl.rsp_cout  = add_cout;
  assign idle         = ~|tag_pipe & ~|cl.req_valid;

`ifdef KS_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetn)                         grant_cnt <= '0;
    else if (xfer && grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_kogge_stone_arbiter.sv
// Directed bench for kogge_stone_arbiter with a behavioural LAT-stage adder attached.
module tb_kogge_stone_arbiter;
  localparam int BW   = 32;
  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic [BW-1:0] add_a, add_b, add_sum;
  logic          add_cin, add_cout, idle;
`ifdef KS_ARB_STATS_EN
  logic [15:0]   grant_cnt;
`endif

  int nvec = 0;
  int nbad = 0;

  kogge_stone_arbiter_if #(.BW(BW), .NREQ(NREQ)) ifc ();

  kogge_stone_arbiter #(.BW(BW), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .cl       (ifc),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .idle     (idle)
`ifdef KS_ARB_STATS_EN
    ,
    .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Adder stand-in: LAT register stages after the operand registers.
  logic [BW:0] apipe [0:(LAT > 0 ? LAT-1 : 0)];
  generate
    if (LAT == 0) begin : g_comb
      assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + (BW+1)'(add_cin);
    end else begin : g_pipe
      always @(posedge clk) begin
        apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + (BW+1)'(add_cin);
        for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
      end
      assign {add_cout, add_sum} = apipe[LAT-1];
    end
  endgenerate

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [BW-1:0] a, input logic [BW-1:0] b, input logic c);
    ifc.req_a[i*BW +: BW] = a;
    ifc.req_b[i*BW +: BW] = b;
    ifc.req_cin[i]        = c;
  endtask

  initial begin
    logic [BW:0] exp_s;
    int          n;
    int          j;

    resetn        = 1'b0;
    ifc.req_valid = '0;
    ifc.req_a     = '0;
    ifc.req_b     = '0;
    ifc.req_cin   = '0;
    tick();
    tick();

    // Reset state
    chk("rst_rsp_valid", ifc.rsp_valid, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_cin", add_cin, 0);
    chk("rst_idle", idle, 1);
    ifc.req_valid = 4'b1111;
    #1;
    chk("rst_ready_gated", ifc.req_ready, 0);
    ifc.req_valid = '0;
    resetn = 1'b1;
    tick();

    // Single request: 100000+100000+1
    set_req(0, 32'd100000, 32'd100000, 1'b1);
    ifc.req_valid = 4'b0001;
    #1;
    chk("single_ready", ifc.req_ready, 4'b0001);
    chk("single_busy", idle, 0);
    tick();
    ifc.req_valid = '0;
    chk("single_add_a", add_a, 100000);
    chk("single_lat0", ifc.rsp_valid, 0);
    tick();
    chk("single_lat1", ifc.rsp_valid, 0);
    tick();
    chk("single_rsp_valid", ifc.rsp_valid, 4'b0001);
    chk("single_sum", ifc.rsp_sum, 200001);
    chk("single_cout", ifc.rsp_cout, 0);
    tick();
    chk("single_done", ifc.rsp_valid, 0);
    chk("single_idle", idle, 1);

    // Contention from reset: grants 0,1,2,3,0 and responses in the same order
    for (int i = 0; i < NREQ; i++) set_req(i, BW'(i*1000 + 1), BW'(i), 1'(i & 1));
    resetn = 1'b0;
    ifc.req_valid = 4'b1111;
    tick();
    resetn = 1'b1;
    #1;
    for (int k = 0; k < 5 + LAT; k++) begin
      if (k < 5) chk($sformatf("cont_ready%0d", k), ifc.req_ready, 4'b0001 << (k % NREQ));
      tick();
      if (k == 4) ifc.req_valid = '0;
      #1;
      if (k >= LAT) begin
        j = (k - LAT) % NREQ;
        chk($sformatf("cont_rsp%0d", k - LAT), ifc.rsp_valid, 4'b0001 << j);
        chk($sformatf("cont_sum%0d", k - LAT), ifc.rsp_sum, j*1000 + 1 + j + (j & 1));
      end
    end

    // Fairness: req0 always valid, req2 pulses twice
    ifc.req_valid = 4'b0001;
    tick();
    tick();
    for (int p = 0; p < 2; p++) begin
      set_req(2, 32'd7, 32'd8, 1'b0);
      ifc.req_valid[2] = 1'b1;
      #1;
      n = 0;
      while (!ifc.req_ready[2] && n < NREQ) begin
        tick();
        n++;
      end
      chk($sformatf("fair_gnt%0d", p), ifc.req_ready, 4'b0100);
      tick();
      ifc.req_valid[2] = 1'b0;
      #1;
      chk($sformatf("fair_back%0d", p), ifc.req_ready, 4'b0001);
      tick();
    end
    ifc.req_valid = '0;
    for (int k = 0; k < LAT + 2; k++) tick();
    chk("fair_drained", idle, 1);

    // Carry wrap cases, back to back from requester 1
    set_req(1, 32'hFFFFFFFF, 32'h0, 1'b1);
    ifc.req_valid = 4'b0010;
    #1;
    chk("wrap_ready0", ifc.req_ready, 4'b0010);
    tick();
    set_req(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    #1;
    chk("wrap_ready1", ifc.req_ready, 4'b0010);
    tick();
    ifc.req_valid = '0;
    tick();
    chk("wrap0_valid", ifc.rsp_valid, 4'b0010);
    chk("wrap0_sum", ifc.rsp_sum, 0);
    chk("wrap0_cout", ifc.rsp_cout, 1);
    tick();
    chk("wrap1_valid", ifc.rsp_valid, 4'b0010);
    exp_s = 33'h1FFFFFFFF;
    chk("wrap1_sum", ifc.rsp_sum, exp_s[BW-1:0]);
    chk("wrap1_cout", ifc.rsp_cout, exp_s[BW]);

    // Reset with three tags in flight
    ifc.req_valid = 4'b1111;
    tick();
    tick();
    tick();
    resetn = 1'b0;
    ifc.req_valid = '0;
    tick();
    resetn = 1'b1;
    #1;
    chk("mid_idle", idle, 1);
    for (int k = 0; k < LAT + 2; k++) begin
      chk($sformatf("mid_no_rsp%0d", k), ifc.rsp_valid, 0);
      tick();
    end
    ifc.req_valid = 4'b1111;
    #1;
    chk("mid_ptr0", ifc.req_ready, 4'b0001);
    ifc.req_valid = '0;
    tick();

`ifdef KS_ARB_STATS_EN
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("stats_rst", grant_cnt, 0);
    ifc.req_valid = 4'b0001;
    for (int k = 0; k < 70000; k++) tick();
    chk("stats_sat", grant_cnt, 16'hFFFF);
    tick();
    tick();
    chk("stats_hold", grant_cnt, 16'hFFFF);
    ifc.req_valid = '0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("stats_clr", grant_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
